// File: rtl/gfsk_mod_multirate.sv
// gfsk_mod_multirate: BTLE GFSK front end; repeat-upsamples bits through a symmetric
// Gaussian FIR with automatic tail flush, producing fmod and a wrapped phase accumulator.
module gfsk_mod_multirate #(
    parameter int MAX_SAMPLE_PER_SYMBOL = 8,
    parameter int GAUSS_FILTER_BIT_WIDTH = 16,
    parameter int NUM_TAP_GAUSS_FILTER = 17,
    parameter int TAP_INDEX_BIT_WIDTH = 4,
    parameter int PHASE_BIT_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              tap_write_en,
    input  logic [TAP_INDEX_BIT_WIDTH-1:0]    tap_index,
    input  logic [GAUSS_FILTER_BIT_WIDTH-1:0] tap_value,
    input  logic                              phy_mode,
    input  logic [1:0]                        fmod_shift,
    input  logic                              phy_bit,
    input  logic                              bit_valid,
    input  logic                              bit_valid_last,
    output logic                              bit_ready,
    output logic [GAUSS_FILTER_BIT_WIDTH-1:0] fmod,
    output logic [PHASE_BIT_WIDTH-1:0]        phase,
    output logic                              sample_valid,
    output logic                              sample_valid_last,
    output logic                              busy
);
    localparam int N = NUM_TAP_GAUSS_FILTER;
    localparam int W = GAUSS_FILTER_BIT_WIDTH;
    localparam int PW = PHASE_BIT_WIDTH;
    localparam int CW = $clog2(MAX_SAMPLE_PER_SYMBOL);
    localparam int FW = $clog2(N);
    localparam int AW = W + $clog2(N);
    localparam int HALF = (N - 1) / 2;
    localparam logic [CW-1:0] LAST_1M = CW'(MAX_SAMPLE_PER_SYMBOL - 1);
    localparam logic [CW-1:0] LAST_2M = CW'(MAX_SAMPLE_PER_SYMBOL / 2 - 1);
    localparam logic signed [AW-1:0] SAT_HI = AW'((1 << (W - 1)) - 1);
    localparam logic signed [AW-1:0] SAT_LO = -SAT_HI - 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, last_cnt;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic bit_q, bit_d, last_q, last_d, mode_q, mode_d, ready_q, ready_d;
    logic in_v_q, in_v_d, in_last_q, in_last_d, sv_q, sv_d, svl_q, svl_d, accept;
    logic [1:0] shift_q, shift_d;
    // Shift register stored as (nonzero, negative) bit pairs: samples are only -1/0/+1.
    logic [N-1:0] nz_q, nz_d, neg_q, neg_d;
    logic signed [W-1:0] h_q [N];
    logic signed [W-1:0] h_d [N];
    logic signed [W-1:0] fmod_q, fmod_d;
    logic [PW-1:0] phase_q, phase_d;
    logic signed [AW-1:0] acc;

    always_comb begin
        accept = bit_valid & ready_q;
        last_cnt = mode_q ? LAST_2M : LAST_1M;
        state_d = state_q;
        bit_d = bit_q;
        last_d = last_q;
        mode_d = mode_q;
        shift_d = shift_q;
        h_d = h_q;
        in_last_d = 1'b0;
        in_v_d = state_q != IDLE;
        cnt_d = cnt_q + 1'b1;
        fcnt_d = fcnt_q + 1'b1;
        nz_d = state_q == IDLE ? '0 : {nz_q[N-2:0], state_q == RUN};
        neg_d = state_q == IDLE ? '0 : {neg_q[N-2:0], state_q == RUN && !bit_q};
        if (state_q == IDLE) begin
            for (int k = 0; k < N; k++)
                if (tap_write_en && int'(tap_index) <= HALF &&
                    (k == int'(tap_index) || k == N - 1 - int'(tap_index)))
                    h_d[k] = $signed(tap_value);
            if (accept) begin
                state_d = RUN;
                cnt_d = '0;
                bit_d = phy_bit;
                last_d = bit_valid_last;
                mode_d = phy_mode;
                shift_d = fmod_shift;
            end
        end else if (state_q == RUN) begin
            if (cnt_q == last_cnt) begin
                if (accept) begin
                    cnt_d = '0;
                    bit_d = phy_bit;
                    last_d = bit_valid_last;
                end else begin
                    state_d = FLUSH;
                    fcnt_d = '0;
                end
            end
        end else if (fcnt_q == FW'(N - 2)) begin
            state_d = IDLE;
            in_last_d = 1'b1;
        end
        ready_d = state_d == IDLE ||
                  (state_d == RUN && !last_d && cnt_d == (mode_d ? LAST_2M : LAST_1M));
        acc = '0;
        for (int k = 0; k < N; k++)
            acc = acc + (nz_q[k] ? (neg_q[k] ? -AW'(h_q[k]) : AW'(h_q[k])) : AW'(0));
        fmod_d = acc > SAT_HI ? W'(SAT_HI) : acc < SAT_LO ? W'(SAT_LO) : W'(acc);
        phase_d = (state_q == IDLE && accept) ? '0 :
                  in_v_q ? phase_q + PW'(fmod_d >>> shift_q) : phase_q;
        sv_d = in_v_q;
        svl_d = in_last_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            fcnt_q <= '0;
            bit_q <= 1'b0;
            last_q <= 1'b0;
            mode_q <= 1'b0;
            shift_q <= '0;
            ready_q <= 1'b0;
            in_v_q <= 1'b0;
            in_last_q <= 1'b0;
            sv_q <= 1'b0;
            svl_q <= 1'b0;
            nz_q <= '0;
            neg_q <= '0;
            fmod_q <= '0;
            phase_q <= '0;
            for (int k = 0; k < N; k++) h_q[k] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            fcnt_q <= fcnt_d;
            bit_q <= bit_d;
            last_q <= last_d;
            mode_q <= mode_d;
            shift_q <= shift_d;
            ready_q <= ready_d;
            in_v_q <= in_v_d;
            in_last_q <= in_last_d;
            sv_q <= sv_d;
            svl_q <= svl_d;
            nz_q <= nz_d;
            neg_q <= neg_d;
            fmod_q <= fmod_d;
            phase_q <= phase_d;
            h_q <= h_d;
        end
    end

    assign bit_ready = ready_q;
    assign fmod = fmod_q;
    assign phase = phase_q;
    assign sample_valid = sv_q;
    assign sample_valid_last = svl_q;
    assign busy = state_q != IDLE;
endmodule

// File: doc/gfsk_mod_multirate.md
Name: gfsk_mod_multirate

Overview:
Parametrised next-generation GFSK modulator front end for the BTLE TX chain. It accepts PHY bits under a ready/valid handshake and repeat-upsamples them at a runtime-selectable rate (LE 1M or LE 2M). Samples pass through a programmable symmetric Gaussian FIR, which automatically flushes the filter tail after the last bit. Outputs are the frequency-modulation word (fmod, for the polar path) and a wrapped phase accumulator (for the IQ path, sin/cos table lookup).

Parameters:
MAX_SAMPLE_PER_SYMBOL, 8, samples per bit in 1M mode; power of 2, >=2.
GAUSS_FILTER_BIT_WIDTH, 16, tap and fmod width (signed).
NUM_TAP_GAUSS_FILTER, 17, FIR length; odd, <=2^TAP_INDEX_BIT_WIDTH*2-1.
TAP_INDEX_BIT_WIDTH, 4, width of tap_index.
PHASE_BIT_WIDTH, 16, phase accumulator width.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
tap_write_en  in  1  tap write strobe
tap_index  in  TAP_INDEX_BIT_WIDTH  half-filter tap index 0..(N-1)/2
tap_value  in  GAUSS_FILTER_BIT_WIDTH  signed tap value
phy_mode  in  1  0: SPS=MAX_SAMPLE_PER_SYMBOL; 1: SPS=MAX_SAMPLE_PER_SYMBOL/2
fmod_shift  in  2  arithmetic right shift applied to fmod before phase accumulation
phy_bit  in  1  data bit
bit_valid  in  1  phy_bit valid
bit_valid_last  in  1  marks last bit of packet
bit_ready  out  1  bit accepted when bit_valid & bit_ready
fmod  out  GAUSS_FILTER_BIT_WIDTH  signed filtered frequency word
phase  out  PHASE_BIT_WIDTH  phase accumulator
sample_valid  out  1  fmod/phase valid
sample_valid_last  out  1  final sample of packet (incl. tail)
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0): all outputs 0, taps 0, shift register 0, state IDLE. First cycle after release: bit_ready=1.
- phy_mode and fmod_shift are sampled on the IDLE accept and held for the whole packet.
- FSM IDLE->RUN on accept. RUN: repeat counter 0..SPS-1, one sample per clock. bit_ready=1 only when counter==SPS-1 and the current bit is not last; an accept there continues RUN seamlessly.
- RUN->FLUSH: at counter==SPS-1 when the current bit was last, or when no accept occurs (underrun, treated as implicit end).
- FLUSH: shift in NUM_TAP-1 zero samples, then go to IDLE and clear the shift register.
- Sample mapping: bit 1 -> +1, bit 0 -> -1, flush -> 0.
- Shift register x[0..N-1], x[0] newest. Taps are symmetric: tap_index k writes h[k] and h[N-1-k].
- Tap writes are applied only in IDLE and take effect the next cycle. Writes are ignored when busy or when tap_index>(N-1)/2.
- Sum of ±h[k]: full-precision accumulator of width GAUSS_FILTER_BIT_WIDTH+clog2(N), then saturated to the signed GAUSS_FILTER_BIT_WIDTH range.
- Latency: a sample entering the shift register at edge t appears on fmod with sample_valid at edge t+1. First valid output comes 2 cycles after the accept. sample_valid is continuous from first sample to last, with no gaps inside a packet.
- Samples per packet = nbits*SPS + N-1. sample_valid_last is high with the final one.
- phase: cleared to 0 on the IDLE accept. Updated with phase <= phase + sext(fmod>>>fmod_shift) in the same cycle fmod is registered, so phase reflects fmods up to and including the current one. Wraps modulo 2^PHASE_BIT_WIDTH.
- Reset mid-packet: immediate abort, all state to reset values. No sample_valid_last is emitted.

Test Plan:
- Center tap (index 8) = 1000, others 0; mode 0; bits 1,0,1(last) -> 40 valid samples: 8x0, 8x+1000, 8x-1000, 8x+1000, 8x0; sample_valid_last on sample 40.
- Mode 1, same taps; bits 1,1(last) with bit_valid held high -> bit_ready pulses 4 cycles apart; 24 samples: 8x0, 8x+1000, 8x0.
- All taps 32767; 3 bits of 1 -> fmod saturates to +32767 at the peak. All-zero bits -> -32768.
- Center tap 1024, fmod_shift=2, one bit 1 (last) -> phase steps +256 per sample, reaches 2048, then holds. Second packet restarts phase at 0.
- Underrun: drop bit_valid after 2 bits -> FLUSH starts, 2*8+16 samples, valid_last asserted. A tap write while busy has no effect.
- Assert rst during RUN -> outputs 0 asynchronously; after release bit_ready=1, taps 0, fmod 0 for a new packet.
